// File: rtl/dpcm_decoder.sv
// Two-phase DPCM decoder: rebuilds interleaved A/B samples from key and delta beats.
// The output is a single register stage, so a new sample can be taken on every clock.
module dpcm_decoder #(
  parameter int unsigned DELTA_SHIFT = 2,
  parameter logic [7:0]  MID_VALUE   = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_key,
  input  logic       in_sync,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sample,
  output logic       out_phase,
  output logic       err
);

  // Handshake: a beat moves when valid && ready on a rising edge. Ready never
  // looks at valid on the same side, and valid holds its payload until ready.
  logic              ph;
  logic [7:0]        pred_a;
  logic [7:0]        pred_b;
  logic              seeded_a;
  logic              seeded_b;

  logic              accept;
  logic              used_ph;
  logic              used_seeded;
  logic [7:0]        used_pred;
  logic signed [9:0] delta_ext;
  logic signed [9:0] sum;
  logic [7:0]        result;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A sync beat wipes both seeded flags before it is applied.
  always_comb begin
    used_ph     = in_sync ? 1'b0 : ph;
    used_seeded = !in_sync && (used_ph ? seeded_b : seeded_a);
    used_pred   = used_seeded ? (used_ph ? pred_b : pred_a) : MID_VALUE;
    delta_ext   = $signed({{6{in_data[3]}}, in_data[3:0]}) <<< DELTA_SHIFT;
    sum         = $signed({2'b00, used_pred}) + delta_ext;
    if (in_key) begin
      result = in_data;
    end else if (sum[9]) begin
      result = 8'd0;
    end else if (sum[8]) begin
      result = 8'hff;
    end else begin
      result = sum[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_sample <= 8'd0;
      out_phase  <= 1'b0;
      err        <= 1'b0;
      ph         <= 1'b0;
      pred_a     <= MID_VALUE;
      pred_b     <= MID_VALUE;
      seeded_a   <= 1'b0;
      seeded_b   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        out_valid  <= 1'b1;
        out_sample <= result;
        out_phase  <= used_ph;
        ph         <= !used_ph;
        if (used_ph) begin
          pred_b <= result;
        end else begin
          pred_a <= result;
        end
        if (in_sync) begin
          seeded_a <= 1'b0;
          seeded_b <= 1'b0;
        end
        // Later assignment wins, so the used phase ends up seeded even on sync.
        if (used_ph) begin
          seeded_b <= 1'b1;
        end else begin
          seeded_a <= 1'b1;
        end
        if (!in_key && !used_seeded) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpcm_decoder.sv
// Bench for dpcm_decoder: directed literal cases plus random traffic, all checked
// against an integer-arithmetic reference model and an expected-output queue.
module tb_dpcm_decoder;
  localparam int SHIFT = 2;
  localparam int MID   = 128;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_key = 1'b0;
  logic       in_sync = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_sample;
  logic       out_phase;
  logic       err;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  bit         ph_q[$];
  int         m_pred[2];
  bit         m_seed[2];
  bit         m_ph;
  bit         m_err;

  dpcm_decoder #(.DELTA_SHIFT(SHIFT), .MID_VALUE(8'(MID))) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_sync(in_sync),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_phase(out_phase), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    ph_q.delete();
    m_pred[0] = MID;
    m_pred[1] = MID;
    m_seed[0] = 1'b0;
    m_seed[1] = 1'b0;
    m_ph = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_beat(input logic [7:0] d, input logic key, input logic sync);
    int u, p, dl, r;
    u = sync ? 0 : (m_ph ? 1 : 0);
    if (sync) begin
      m_seed[0] = 1'b0;
      m_seed[1] = 1'b0;
    end
    if (key) begin
      r = int'(d);
    end else begin
      p = m_seed[u] ? m_pred[u] : MID;
      if (!m_seed[u]) m_err = 1'b1;
      dl = int'(d[3:0]);
      if (dl > 7) dl -= 16;
      r = p + dl * (1 << SHIFT);
      if (r < 0) r = 0;
      if (r > 255) r = 255;
    end
    m_pred[u] = r;
    m_seed[u] = 1'b1;
    m_ph = (u == 0);
    exp_q.push_back(8'(r));
    ph_q.push_back(u == 1);
  endfunction

  // Model update on the clock edge, using inputs as they stand at the edge.
  always begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      model_reset();
    end else begin
      automatic bit rdy = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() > 0 && out_ready) begin
        void'(exp_q.pop_front());
        void'(ph_q.pop_front());
      end
      if (in_valid && rdy) model_beat(in_data, in_key, in_sync);
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
      chk("out_valid", out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        chk("out_sample", out_sample, exp_q[0]);
        chk("out_phase", out_phase, ph_q[0]);
      end
      chk("err", err, m_err);
    end
  end

  task automatic beat(input logic [7:0] d, input logic key, input logic sync,
                      input logic [7:0] es, input logic ep);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = d; in_key = key; in_sync = sync; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_sync = 1'b0;
    @(negedge clk);
    chk("lit_valid", out_valid, 1);
    chk("lit_sample", out_sample, es);
    chk("lit_phase", out_phase, ep);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sample", out_sample, 0);
    chk("rst_phase", out_phase, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_run(input int n);
    logic hold;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hold = in_valid && !in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_key   = ($urandom_range(0, 3) == 0);
        in_sync  = ($urandom_range(0, 15) == 0);
        in_data  = 8'($urandom);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sync = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("init_valid", out_valid, 0);
    chk("init_sample", out_sample, 0);
    chk("init_phase", out_phase, 0);
    chk("init_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic keys and deltas on both phases
    beat(8'd100, 1, 0, 8'd100, 0);
    beat(8'd200, 1, 0, 8'd200, 1);
    beat(8'h03, 0, 0, 8'd112, 0);
    beat(8'hAE, 0, 0, 8'd192, 1);
    chk("lit_err0", err, 0);

    // Clamping high and low
    beat(8'd250, 1, 1, 8'd250, 0);
    beat(8'd5, 1, 0, 8'd5, 1);
    beat(8'h07, 0, 0, 8'd255, 0);
    beat(8'h08, 0, 0, 8'd0, 1);
    chk("lit_err1", err, 0);

    // Mid-line sync while ph=B forces phase A and unseeds B
    beat(8'd50, 1, 0, 8'd50, 0);
    beat(8'd60, 1, 1, 8'd60, 0);
    beat(8'h01, 0, 0, 8'd132, 1);
    chk("lit_err_sync", err, 1);

    // Delta before any key after reset
    pulse_reset();
    beat(8'h01, 0, 0, 8'd132, 0);
    chk("lit_err_unseeded", err, 1);

    // Back-pressure: output frozen for 5 cycles, then released in order
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_key = 1'b1; in_sync = 1'b0; in_data = 8'd10;
    @(posedge clk); #1;
    in_data = 8'd20;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_sample", out_sample, 10);
      chk("stall_phase", out_phase, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("release_sample", out_sample, 20);
    chk("release_phase", out_phase, 0);

    rand_run(600);
    chk("lit_err_sticky", err, 1);

    // Asynchronous reset while a sample is held
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_key = 1'b1; in_data = 8'd77;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("held_valid", out_valid, 1);
    pulse_reset();
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    rand_run(400);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drain_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpcm_decoder.md
DPCM_DECODER -- requirements
Module: dpcm_decoder

Interface
REQ-001 SHALL have parameter DELTA_SHIFT, default 2, left shift applied to each decoded delta before accumulation (legal 0..4).
REQ-002 SHALL have parameter MID_VALUE, default 8'd128, predictor value for a phase that has not been seeded.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_ready  output  1  decoder accepts beat this cycle.
REQ-007 SHALL have port in_data  input  8  key: absolute sample; delta: [3:0] signed delta, [7:4] ignored.
REQ-008 SHALL have port in_key  input  1  beat is an absolute key sample.
REQ-009 SHALL have port in_sync  input  1  beat starts a line; forces phase A for this beat.
REQ-010 SHALL have port out_valid  output  1  reconstructed sample present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts sample.
REQ-012 SHALL have port out_sample  output  8  reconstructed unsigned sample.
REQ-013 SHALL have port out_phase  output  1  0 = phase A, 1 = phase B, for out_sample.
REQ-014 SHALL have port err  output  1  sticky: delta received for an unseeded phase.

Function
REQ-015 SHALL treat a beat as accepted when in_valid && in_ready are high on the same rising edge.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (one-entry output register, no combinational path from in_valid to in_ready).
REQ-017 SHALL keep two independent 8-bit predictors, pred_A and pred_B, plus seeded_A and seeded_B flags.
REQ-018 SHALL keep phase register ph; an accepted beat uses phase ph, or phase A when in_sync=1.
REQ-019 SHALL set ph to the opposite of the used phase after each accepted beat (A,B,A,B...); in_sync therefore makes the next beat phase B.
REQ-020 SHALL, on an accepted key beat: result = in_data, set the used phase's seeded flag.
REQ-021 SHALL, on an accepted delta beat: result = clamp(pred + (sext(in_data[3:0]) << DELTA_SHIFT), 0, 255), computed in at least 10-bit signed arithmetic.
REQ-022 SHALL use MID_VALUE as pred for a delta on an unseeded phase, set err, and mark that phase seeded.
REQ-023 SHALL write result into the used phase's predictor and load out_sample/out_phase with result/used phase in the accepting cycle; out_valid=1 next cycle.
REQ-024 SHALL hold out_sample, out_phase and out_valid stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid on a cycle with out_valid && out_ready and no accepted beat; a simultaneous accept reloads it (full throughput, 1 sample/clock).
REQ-026 SHALL give 1-cycle latency from accepted beat to out_valid.
REQ-027 SHALL clear seeded_A and seeded_B on accepted in_sync beats before applying that beat; predictors keep values but are unused until reseeded.
REQ-028 SHALL never drop or duplicate a beat under any in_valid/out_ready pattern.

Reset
REQ-029 SHALL, while rst_n=0, force out_valid=0, out_sample=0, out_phase=0, err=0, ph=A, pred_A=pred_B=MID_VALUE, seeded flags=0, independent of clk.
REQ-030 SHALL, when reset asserts mid-transfer, discard any held output sample; in_ready=1 from the first cycle after release.
REQ-031 SHALL clear err only by reset.

Verification
REQ-032 Key A=100, key B=200, deltas +3,-2 (SHIFT=2), out_ready=1 -> outputs 100/A, 200/B, 112/A, 192/B, each one cycle after accept; err=0.
REQ-033 Key A=250, delta +7 (SHIFT=2) -> 255 (clamp high); key B=5, delta -8 -> 0 (clamp low).
REQ-034 After reset, delta +1 on phase A with no key -> out 132, err=1 and stays 1 through later valid traffic.
REQ-035 out_ready held low 5 cycles with in_valid=1 -> in_ready=0, out_sample frozen; release -> next samples in order, none lost or repeated.
REQ-036 Mid-line in_sync key beat while ph=B -> sample tagged phase A, next beat phase B, seeded flags cleared (delta on B before key sets err).
REQ-037 rst_n pulsed low asynchronously while out_valid=1, out_ready=0 -> out_valid=0 immediately, all outputs at reset values.
